// File: rtl/square_rr_sched.sv
// rtl/square_rr_sched.sv - round-robin scheduler sharing one registered squarer among NUM_REQ requesters
module square_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int N_W     = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*N_W-1:0] req_n,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [2*N_W-1:0]       rsp_n2,
  input  logic                   rsp_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t            state;
  state_t            state_nx;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   cap_id;
  logic [ID_W-1:0]   gnt;
  logic              found;
  logic [N_W-1:0]    op;
  logic [2*N_W-1:0]  op_w;
  int                idx;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready = NUM_REQ'(1) << gnt;
          state_nx  = CALC;
        end
      end
      CALC:    state_nx = HOLD;
      HOLD:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign op_w = {{N_W{1'b0}}, op};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      cap_id     <= '0;
      op         <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_n2     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (found) begin
            op         <= req_n[gnt*N_W +: N_W];
            cap_id     <= gnt;
            last_grant <= gnt;
          end
        end
        CALC: begin
          rsp_n2    <= op_w * op_w;
          rsp_id    <= cap_id;
          rsp_valid <= 1'b1;
        end
        HOLD: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_square_rr_sched.sv
// tb/tb_square_rr_sched.sv - vector table plus result scoreboard for square_rr_sched
module tb_square_rr_sched;

  logic        clk;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [15:0] req_n;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_n2;
  logic        rsp_ready;
  logic        busy;

  square_rr_sched #(.NUM_REQ(4), .N_W(4), .ID_W(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_n     (req_n),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_n2    (rsp_n2),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] ns;
    int          g;
    int          hold;
  } vec_t;

  typedef struct {
    int id;
    int n2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard pops at the falling edge, where a handshake is about to complete.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rstn) begin
      chk("rsp_n2_known", 32'($isunknown(rsp_n2)), 0);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_rsp_id", rsp_id, e.id);
          chk("sb_rsp_n2", rsp_n2, e.n2);
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_grant(output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 10; t++) begin
      #1;
      if (req_ready != 4'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("grant_timeout", 1, 0);
  endtask

  task automatic run_vec(input vec_t v);
    logic ok;
    int   n;
    exp_t e;
    req_valid = v.valid;
    req_n     = v.ns;
    rsp_ready = (v.hold == 0);
    wait_grant(ok);
    if (!ok) return;
    chk("grant", req_ready, 32'(1) << v.g);
    chk("idle_busy", busy, 0);
    n    = int'(v.ns[v.g*4 +: 4]);
    e.id = v.g;
    e.n2 = n * n;
    sb.push_back(e);
    tick();
    req_valid = 4'b0;
    #1;
    chk("calc_busy", busy, 1);
    chk("calc_req_ready", req_ready, 0);
    chk("calc_rsp_valid", rsp_valid, 0);
    tick();
    chk("latency_rsp_valid", rsp_valid, 1);
    if (v.hold > 0) begin
      req_valid = 4'hF;
      for (int i = 0; i < v.hold; i++) begin
        #1;
        chk("hold_rsp_valid", rsp_valid, 1);
        chk("hold_rsp_id", rsp_id, e.id);
        chk("hold_rsp_n2", rsp_n2, e.n2);
        chk("hold_req_ready", req_ready, 0);
        tick();
      end
      req_valid = 4'b0;
      rsp_ready = 1'b1;
    end
    tick();
    chk("released_rsp_valid", rsp_valid, 0);
    chk("released_busy", busy, 0);
  endtask

  vec_t vecs[8];
  logic ok;
  exp_t e;

  initial begin
    vecs[0] = '{4'b0100, 16'h0F00, 2, 0};
    vecs[1] = '{4'b1001, 16'h7000, 3, 0};
    vecs[2] = '{4'b1001, 16'h7000, 0, 0};
    vecs[3] = '{4'b0011, 16'h0065, 1, 0};
    vecs[4] = '{4'b0001, 16'h000F, 0, 10};
    vecs[5] = '{4'b1110, 16'h3210, 1, 0};
    vecs[6] = '{4'b1100, 16'hA900, 2, 0};
    vecs[7] = '{4'b1010, 16'hC040, 3, 0};

    rstn      = 1'b0;
    req_valid = 4'b0;
    req_n     = 16'h0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_n2", rsp_n2, 0);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // All four contending with rsp_ready held high: strict rotation, one grant per 3 cycles.
    req_valid = 4'hF;
    req_n     = 16'h4321;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(ok);
      if (!ok) break;
      chk("rr_grant", req_ready, 32'(1) << (k % 4));
      if (k > 0) chk("rr_gap", cyc - last_cyc, 3);
      last_cyc = cyc;
      e.id = k % 4;
      e.n2 = (k % 4 + 1) * (k % 4 + 1);
      sb.push_back(e);
      tick();
    end
    req_valid = 4'b0;
    for (int t = 0; t < 10 && (busy || sb.size() != 0); t++) tick();
    chk("rr_drain", sb.size(), 0);

    // Reset asserted while CALC is in flight: the result must never appear.
    req_valid = 4'b0010;
    req_n     = 16'h0050;
    wait_grant(ok);
    chk("mid_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0;
    chk("mid_calc_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_rsp_valid", rsp_valid, 0);
    chk("async_rsp_id", rsp_id, 0);
    chk("async_rsp_n2", rsp_n2, 0);
    tick();
    tick();
    rstn = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("post_rst_rsp_valid", rsp_valid, 0);
    end
    run_vec('{4'b0011, 16'h0023, 0, 0});
    run_vec('{4'b0011, 16'h0023, 1, 0});
    chk("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
